// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART blocks.
//   uart_tx_state_t : transmitter FSM states
//   uart_parity_t   : runtime parity selection carried on parity_mode
//   parity_bit()    : parity value to place on the line for a data word
//   parity_enabled(): whether a parity bit slot exists in the frame
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_RSVD = 2'b11
  } uart_parity_t;

  // Widest supported data word; narrower words are zero-extended, which
  // leaves their XOR reduction unchanged.
  localparam int unsigned MAX_DATA_BITS = 9;

  // Even parity makes the total count of ones even, odd makes it odd.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input uart_parity_t mode);
    logic red_s;
    red_s = ^data;
    case (mode)
      PAR_EVEN: return red_s;
      PAR_ODD:  return ~red_s;
      default:  return 1'b0;
    endcase
  endfunction

  // The reserved encoding behaves exactly like "no parity".
  function automatic logic parity_enabled(input uart_parity_t mode);
    case (mode)
      PAR_EVEN: return 1'b1;
      PAR_ODD:  return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer shared by the UART transmitter and receiver.
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   en       : run enable; the counter is held at zero while low
//   bit_tick : one-cycle pulse in the last cycle of every CLKS_PER_BIT period
// The first tick after en rises comes CLKS_PER_BIT cycles later, so a bit
// that starts in the same cycle as en lasts exactly one bit period.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);

  logic [CW-1:0] cnt_r;

  // Baud counter: cleared when disabled, wraps at the last cycle of a bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else if (!en) begin
      cnt_r <= CNT_ZERO;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  assign bit_tick = en && (cnt_r == CNT_LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter.
//   clk         : system clock, rising edge
//   rst         : synchronous active-high reset; aborts any frame in flight
//   tx_start    : send request, accepted only while idle
//   tx_data     : word to send, captured on acceptance
//   parity_mode : 00 none, 01 even, 10 odd, 11 treated as none
//   two_stop    : 0 one stop bit, 1 two stop bits
//   tx_serial   : serial line, idles high
//   tx_busy     : high while a frame is on the line
//   tx_done     : one-cycle pulse in the cycle after the last stop bit
// Frame: start(0), DATA_BITS data bits LSB first, optional parity, 1 or 2
// stop bits(1). All configuration is captured with the data so a frame is
// never disturbed by input changes while it is being sent. Every output is
// driven straight from a flop.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_cfg: CLKS_PER_BIT must be at least 2");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be in the range 5..9");
  end

  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1'b1);
  localparam logic [BIT_W-1:0] BIT_ZERO = BIT_W'(1'b0);

  uart_tx_state_t       state_r,     state_nxt_s;
  logic [DATA_BITS-1:0] shift_r,     shift_nxt_s;
  logic [BIT_W-1:0]     bit_idx_r,   bit_idx_nxt_s;
  logic                 stop_idx_r,  stop_idx_nxt_s;
  logic                 parity_r,    parity_nxt_s;
  logic                 par_en_r,    par_en_nxt_s;
  logic                 two_stop_r,  two_stop_nxt_s;
  logic                 tx_serial_r, serial_nxt_s;
  logic                 tx_busy_r,   busy_nxt_s;
  logic                 tx_done_r,   done_nxt_s;

  logic                 baud_en_s;
  logic                 bit_tick_s;
  uart_parity_t         mode_in_s;

  assign mode_in_s = uart_parity_t'(parity_mode);
  assign baud_en_s = (state_r != IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .en       (baud_en_s),
    .bit_tick (bit_tick_s)
  );

  // Next-state and next-output logic; the line level for the next bit is
  // computed here so it appears on tx_serial together with the state change.
  always_comb begin
    state_nxt_s    = state_r;
    shift_nxt_s    = shift_r;
    bit_idx_nxt_s  = bit_idx_r;
    stop_idx_nxt_s = stop_idx_r;
    parity_nxt_s   = parity_r;
    par_en_nxt_s   = par_en_r;
    two_stop_nxt_s = two_stop_r;
    serial_nxt_s   = tx_serial_r;
    busy_nxt_s     = tx_busy_r;
    done_nxt_s     = 1'b0;

    case (state_r)
      IDLE: begin
        serial_nxt_s = 1'b1;
        busy_nxt_s   = 1'b0;
        if (tx_start) begin
          state_nxt_s    = START;
          shift_nxt_s    = tx_data;
          parity_nxt_s   = parity_bit(MAX_DATA_BITS'(tx_data), mode_in_s);
          par_en_nxt_s   = parity_enabled(mode_in_s);
          two_stop_nxt_s = two_stop;
          bit_idx_nxt_s  = BIT_ZERO;
          stop_idx_nxt_s = 1'b0;
          serial_nxt_s   = 1'b0;
          busy_nxt_s     = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end

      START: begin
        if (bit_tick_s) begin
          state_nxt_s  = DATA;
          serial_nxt_s = shift_r[0];
          shift_nxt_s  = {1'b0, shift_r[DATA_BITS-1:1]};
        end else begin
          state_nxt_s = START;
        end
      end

      // shift_r[0] always holds the bit that goes out at the next tick.
      DATA: begin
        if (bit_tick_s) begin
          if (bit_idx_r == BIT_LAST) begin
            if (par_en_r) begin
              state_nxt_s  = PARITY;
              serial_nxt_s = parity_r;
            end else begin
              state_nxt_s  = STOP;
              serial_nxt_s = 1'b1;
            end
          end else begin
            bit_idx_nxt_s = bit_idx_r + BIT_ONE;
            serial_nxt_s  = shift_r[0];
            shift_nxt_s   = {1'b0, shift_r[DATA_BITS-1:1]};
          end
        end else begin
          state_nxt_s = DATA;
        end
      end

      PARITY: begin
        if (bit_tick_s) begin
          state_nxt_s  = STOP;
          serial_nxt_s = 1'b1;
        end else begin
          state_nxt_s = PARITY;
        end
      end

      STOP: begin
        serial_nxt_s = 1'b1;
        if (bit_tick_s) begin
          if (stop_idx_r || !two_stop_r) begin
            state_nxt_s = IDLE;
            busy_nxt_s  = 1'b0;
            done_nxt_s  = 1'b1;
          end else begin
            stop_idx_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = STOP;
        end
      end

      default: begin
        state_nxt_s  = IDLE;
        serial_nxt_s = 1'b1;
        busy_nxt_s   = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      shift_r     <= {DATA_BITS{1'b0}};
      bit_idx_r   <= BIT_ZERO;
      stop_idx_r  <= 1'b0;
      parity_r    <= 1'b0;
      par_en_r    <= 1'b0;
      two_stop_r  <= 1'b0;
      tx_serial_r <= 1'b1;
      tx_busy_r   <= 1'b0;
      tx_done_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      shift_r     <= shift_nxt_s;
      bit_idx_r   <= bit_idx_nxt_s;
      stop_idx_r  <= stop_idx_nxt_s;
      parity_r    <= parity_nxt_s;
      par_en_r    <= par_en_nxt_s;
      two_stop_r  <= two_stop_nxt_s;
      tx_serial_r <= serial_nxt_s;
      tx_busy_r   <= busy_nxt_s;
      tx_done_r   <= done_nxt_s;
    end
  end

  assign tx_serial = tx_serial_r;
  assign tx_busy   = tx_busy_r;
  assign tx_done   = tx_done_r;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: a frame-level reference model checks
// every cycle of two instances (4 clk/bit x 8 bits, 2 clk/bit x 5 bits), a
// table of frames checks lengths and parity slots, and hand-written
// sequences cover reset, back-to-back, ignore, latching and abort.
module tb_uart_tx_cfg;

  localparam int CPB  = 4;
  localparam int DB   = 8;
  localparam int CPB5 = 2;
  localparam int DB5  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tx_start, two_stop;
  logic [7:0] tx_data;
  logic [1:0] parity_mode;
  logic       serial, busy, done;

  logic       start5, ts5;
  logic [4:0] data5;
  logic [1:0] pm5;
  logic       serial5, busy5, done5;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .parity_mode(parity_mode), .two_stop(two_stop),
    .tx_serial(serial), .tx_busy(busy), .tx_done(done)
  );

  uart_tx_cfg #(.CLKS_PER_BIT(CPB5), .DATA_BITS(DB5)) dut5 (
    .clk(clk), .rst(rst), .tx_start(start5), .tx_data(data5),
    .parity_mode(pm5), .two_stop(ts5),
    .tx_serial(serial5), .tx_busy(busy5), .tx_done(done5)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Number of bit slots in a frame.
  function automatic int frame_bits(input logic [1:0] pm, input logic two, input int db);
    return 1 + db + (((pm == 2'b01) || (pm == 2'b10)) ? 1 : 0) + (two ? 2 : 1);
  endfunction

  // Line level of bit slot idx, derived from the frame rules by counting ones.
  function automatic logic frame_bit(input logic [8:0] d, input logic [1:0] pm,
                                     input int db, input int idx);
    int ones;
    ones = $countones(d);
    if (idx == 0) return 1'b0;
    if (idx <= db) return d[idx-1];
    if ((idx == db + 1) && ((pm == 2'b01) || (pm == 2'b10)))
      return (pm == 2'b01) ? ((ones % 2) == 1) : ((ones % 2) == 0);
    return 1'b1;
  endfunction

  // Reference model: queue of expected line levels, front = current cycle.
  logic q8[$];
  logic q5[$];
  logic exp_serial = 1'b1, exp_busy = 1'b0, exp_done = 1'b0;
  logic exp_serial5 = 1'b1, exp_busy5 = 1'b0, exp_done5 = 1'b0;

  always @(posedge clk) begin
    bit had;
    int n;
    if (rst) begin
      q8.delete();
      exp_done = 1'b0;
    end else begin
      had = (q8.size() > 0);
      if (had) void'(q8.pop_front());
      exp_done = had && (q8.size() == 0);
      if (!had && tx_start) begin
        n = frame_bits(parity_mode, two_stop, DB);
        for (int i = 0; i < n; i++)
          for (int k = 0; k < CPB; k++)
            q8.push_back(frame_bit({1'b0, tx_data}, parity_mode, DB, i));
      end
    end
    exp_serial = (q8.size() > 0) ? q8[0] : 1'b1;
    exp_busy   = (q8.size() > 0);
  end

  always @(posedge clk) begin
    bit had;
    int n;
    if (rst) begin
      q5.delete();
      exp_done5 = 1'b0;
    end else begin
      had = (q5.size() > 0);
      if (had) void'(q5.pop_front());
      exp_done5 = had && (q5.size() == 0);
      if (!had && start5) begin
        n = frame_bits(pm5, ts5, DB5);
        for (int i = 0; i < n; i++)
          for (int k = 0; k < CPB5; k++)
            q5.push_back(frame_bit({4'b0000, data5}, pm5, DB5, i));
      end
    end
    exp_serial5 = (q5.size() > 0) ? q5[0] : 1'b1;
    exp_busy5   = (q5.size() > 0);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_serial",  serial,  exp_serial);
      check("model_busy",    busy,    exp_busy);
      check("model_done",    done,    exp_done);
      check("model_serial5", serial5, exp_serial5);
      check("model_busy5",   busy5,   exp_busy5);
      check("model_done5",   done5,   exp_done5);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Sends one frame on the 8-bit instance and measures it from the first
  // cycle after acceptance (k=1) up to the tx_done cycle.
  task automatic run_frame(input logic [7:0] d, input logic [1:0] pm, input logic two,
                           output int busy_cnt, output int done_at,
                           output logic l38, output logic l42, output logic l46);
    busy_cnt = 0; done_at = -1; l38 = 1'b1; l42 = 1'b1; l46 = 1'b1;
    @(negedge clk);
    tx_data = d; parity_mode = pm; two_stop = two; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (k > 1) @(negedge clk);
      if (busy) busy_cnt++;
      if (k == 38) l38 = serial;
      if (k == 42) l42 = serial;
      if (k == 46) l46 = serial;
      if (done) begin
        done_at = k;
        break;
      end
    end
    if (done_at < 0) check("frame_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [1:0] pm;
    logic       two;
    int         exp_busy;
    logic       exp_bit9;
  } vec_t;

  vec_t tbl[7];
  logic [9:0] pat;
  logic [6:0] pat5;

  initial begin
    int bc, da, dc;
    logic l38, l42, l46;
    bit seen;

    tbl[0] = '{8'hA5, 2'b00, 1'b0, 40, 1'b1};
    tbl[1] = '{8'hA5, 2'b01, 1'b0, 44, 1'b0};
    tbl[2] = '{8'hA5, 2'b10, 1'b1, 48, 1'b1};
    tbl[3] = '{8'h3C, 2'b01, 1'b1, 48, 1'b0};
    tbl[4] = '{8'h01, 2'b10, 1'b0, 44, 1'b0};
    tbl[5] = '{8'h07, 2'b01, 1'b0, 44, 1'b1};
    tbl[6] = '{8'hFF, 2'b11, 1'b0, 40, 1'b1};
    pat  = 10'b1101001010;  // A5 frame, slot 0 in bit 0
    pat5 = 7'b1100110;      // 5'h13 frame, slot 0 in bit 0

    rst = 1'b1; tx_start = 1'b0; tx_data = 8'h00; parity_mode = 2'b00; two_stop = 1'b0;
    start5 = 1'b0; data5 = 5'h00; pm5 = 2'b00; ts5 = 1'b0;

    // Reset idle
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      chk_en = 1'b1;
      check("rst_serial", serial, 1'b1);
      check("rst_busy",   busy,   1'b0);
      check("rst_done",   done,   1'b0);
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_serial", serial, 1'b1);
      check("idle_busy",   busy,   1'b0);
    end

    // Table of frames
    for (int i = 0; i < 7; i++) begin
      run_frame(tbl[i].data, tbl[i].pm, tbl[i].two, bc, da, l38, l42, l46);
      check($sformatf("tbl%0d_busy_cycles", i), bc, tbl[i].exp_busy);
      check($sformatf("tbl%0d_done_at", i), da, tbl[i].exp_busy + 1);
      check($sformatf("tbl%0d_slot9", i), l38, tbl[i].exp_bit9);
      if (tbl[i].two) begin
        check($sformatf("tbl%0d_stop1", i), l42, 1'b1);
        check($sformatf("tbl%0d_stop2", i), l46, 1'b1);
      end
    end

    // A5 pattern with inputs changed after accept, tx_start held (ignored
    // mid-frame, accepted in the tx_done cycle)
    @(negedge clk);
    tx_data = 8'hA5; parity_mode = 2'b00; two_stop = 1'b0; tx_start = 1'b1;
    @(negedge clk);
    tx_data = 8'hFF; parity_mode = 2'b10; two_stop = 1'b1;
    for (int k = 1; k <= 41; k++) begin
      if (k > 1) @(negedge clk);
      if ((k % 4) == 2) check($sformatf("a5_slot%0d", (k - 2) / 4), serial, pat[(k - 2) / 4]);
    end
    check("a5_done", done, 1'b1);
    check("a5_done_busy", busy, 1'b0);
    @(negedge clk);
    tx_start = 1'b0;
    check("b2b_start", serial, 1'b0);
    check("b2b_busy", busy, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("b2b_second_done", seen, 1'b1);
    repeat (2) @(negedge clk);

    // Abort during data bit 3
    tx_data = 8'hA5; parity_mode = 2'b00; two_stop = 1'b0; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (17) @(negedge clk);
    check("abort_pre_slot4", serial, pat[4]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_serial", serial, 1'b1);
    check("abort_busy",   busy,   1'b0);
    dc = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dc++;
    end
    check("abort_no_done", dc, 0);

    // 5-bit, 2 clk/bit instance
    data5 = 5'h13; pm5 = 2'b00; ts5 = 1'b0; start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      if (k > 1) @(negedge clk);
      if ((k % 2) == 0) check($sformatf("d5_slot%0d", (k - 2) / 2), serial5, pat5[(k - 2) / 2]);
    end
    check("d5_done", done5, 1'b1);
    check("d5_busy", busy5, 1'b0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst         = ($urandom_range(0, 499) == 0);
      tx_start    = ($urandom_range(0, 7) == 0);
      tx_data     = 8'($urandom);
      parity_mode = 2'($urandom_range(0, 3));
      two_stop    = 1'($urandom_range(0, 1));
      start5      = ($urandom_range(0, 5) == 0);
      data5       = 5'($urandom);
      pm5         = 2'($urandom_range(0, 3));
      ts5         = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    rst = 1'b0; tx_start = 1'b0; start5 = 1'b0;
    repeat (60) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
